// File: rtl/wb_stage_pipe.sv
// Writeback stage: holds one instruction behind a valid/allowin handshake,
// commits it to the regfile or reports its exception, and counts retirements.
module wb_stage_pipe #(
  parameter int DATA_W = 32,
  parameter int EXC_W  = 7,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              ms_valid,
  output logic              ws_allowin,
  input  logic [DATA_W-1:0] ms_d1,
  input  logic [DATA_W-1:0] ms_d2,
  input  logic              ms_mem_to_reg,
  input  logic              ms_from_cp0,
  input  logic              ms_rf_we,
  input  logic [REG_AW-1:0] ms_dest,
  input  logic [EXC_W-1:0]  ms_except,
  input  logic [DATA_W-1:0] ms_pc,
  output logic              cp0_rd_req,
  input  logic [DATA_W-1:0] cp0_rdata,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              wb_except,
  output logic [4:0]        wb_excode,
  output logic [DATA_W-1:0] wb_epc,
  output logic              fwd_valid,
  output logic [REG_AW-1:0] fwd_dest,
  output logic              fwd_data_ok,
  output logic [DATA_W-1:0] fwd_data,
  output logic [CNT_W-1:0]  retire_cnt
);

  typedef enum logic [1:0] {
    S_EMPTY    = 2'd0,
    S_VALID    = 2'd1,
    S_CP0_WAIT = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                rf_we_q, rf_we_d;
  logic [REG_AW-1:0]   dest_q, dest_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [EXC_W-1:0]    except_q, except_d;
  logic [DATA_W-1:0]   pc_q, pc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic                ready_go;
  logic                accept;
  logic                exc_any;
  logic [4:0]          excode;

  assign ready_go = (state_q == S_VALID);
  assign accept   = ms_valid && ws_allowin;
  assign exc_any  = |except_q;

  // Lowest-numbered architectural cause wins; bits above 6 only map to 0x1F.
  function automatic logic [4:0] cause_code(input int idx);
    case (idx)
      0:       return 5'h00;
      1:       return 5'h04;
      2:       return 5'h05;
      3:       return 5'h0C;
      4:       return 5'h08;
      5:       return 5'h09;
      default: return 5'h0A;
    endcase
  endfunction

  always_comb begin
    excode = exc_any ? 5'h1F : 5'h00;
    for (int i = 6; i >= 0; i--) begin
      if (except_q[i]) excode = cause_code(i);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= S_EMPTY;
      rf_we_q  <= 1'b0;
      dest_q   <= '0;
      data_q   <= '0;
      except_q <= '0;
      pc_q     <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      rf_we_q  <= rf_we_d;
      dest_q   <= dest_d;
      data_q   <= data_d;
      except_q <= except_d;
      pc_q     <= pc_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d = S_EMPTY;
    case (state_q)
      S_CP0_WAIT: state_d = S_VALID;
      default: begin
        if (accept)
          state_d = (ms_from_cp0 && ms_except == '0) ? S_CP0_WAIT : S_VALID;
      end
    endcase
  end

  always_comb begin
    rf_we_d  = rf_we_q;
    dest_d   = dest_q;
    data_d   = data_q;
    except_d = except_q;
    pc_d     = pc_q;
    cnt_d    = cnt_q;
    if (ready_go && !exc_any) cnt_d = cnt_q + CNT_W'(1);
    // The CP0 result overwrites the data latched at accept.
    if (state_q == S_CP0_WAIT) begin
      data_d = cp0_rdata;
    end else if (accept) begin
      rf_we_d  = ms_rf_we;
      dest_d   = ms_dest;
      data_d   = ms_mem_to_reg ? ms_d1 : ms_d2;
      except_d = ms_except;
      pc_d     = ms_pc;
    end
  end

  always_comb begin
    ws_allowin  = (state_q == S_EMPTY) || ready_go;
    cp0_rd_req  = (state_q == S_CP0_WAIT);
    rf_we       = ready_go && rf_we_q && !exc_any;
    rf_waddr    = dest_q;
    rf_wdata    = data_q;
    wb_except   = ready_go && exc_any;
    wb_excode   = wb_except ? excode : 5'h00;
    wb_epc      = wb_except ? pc_q : '0;
    fwd_valid   = (state_q != S_EMPTY) && rf_we_q && !exc_any;
    fwd_dest    = dest_q;
    fwd_data_ok = ready_go;
    fwd_data    = data_q;
    retire_cnt  = cnt_q;
  end

endmodule

// File: tb/tb_wb_stage_pipe.sv
// Bench for wb_stage_pipe: directed scenarios plus randomized traffic checked
// against a one-slot transaction model of the stage.
module tb_wb_stage_pipe;
  localparam int DATA_W = 32;
  localparam int EXC_W  = 9;
  localparam int REG_AW = 5;
  localparam int CNT_W  = 8;

  logic              clk = 1'b0;
  logic              resetn;
  logic              ms_valid;
  logic              ws_allowin;
  logic [DATA_W-1:0] ms_d1, ms_d2;
  logic              ms_mem_to_reg, ms_from_cp0, ms_rf_we;
  logic [REG_AW-1:0] ms_dest;
  logic [EXC_W-1:0]  ms_except;
  logic [DATA_W-1:0] ms_pc;
  logic              cp0_rd_req;
  logic [DATA_W-1:0] cp0_rdata;
  logic              rf_we;
  logic [REG_AW-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic              wb_except;
  logic [4:0]        wb_excode;
  logic [DATA_W-1:0] wb_epc;
  logic              fwd_valid;
  logic [REG_AW-1:0] fwd_dest;
  logic              fwd_data_ok;
  logic [DATA_W-1:0] fwd_data;
  logic [CNT_W-1:0]  retire_cnt;

  int tests_run = 0;
  int failures  = 0;

  // Model: at most one held instruction, optionally still waiting for CP0.
  logic              m_valid = 1'b0;
  logic              m_wait  = 1'b0;
  logic              m_we;
  logic [REG_AW-1:0] m_dest;
  logic [DATA_W-1:0] m_data;
  logic [EXC_W-1:0]  m_exc;
  logic [DATA_W-1:0] m_pc;
  logic [CNT_W-1:0]  m_cnt = '0;

  wb_stage_pipe #(.DATA_W(DATA_W), .EXC_W(EXC_W), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .clk(clk), .resetn(resetn), .ms_valid(ms_valid), .ws_allowin(ws_allowin),
    .ms_d1(ms_d1), .ms_d2(ms_d2), .ms_mem_to_reg(ms_mem_to_reg),
    .ms_from_cp0(ms_from_cp0), .ms_rf_we(ms_rf_we), .ms_dest(ms_dest),
    .ms_except(ms_except), .ms_pc(ms_pc), .cp0_rd_req(cp0_rd_req),
    .cp0_rdata(cp0_rdata), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .wb_except(wb_except), .wb_excode(wb_excode),
    .wb_epc(wb_epc), .fwd_valid(fwd_valid), .fwd_dest(fwd_dest),
    .fwd_data_ok(fwd_data_ok), .fwd_data(fwd_data), .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [4:0] ref_excode(input logic [EXC_W-1:0] e);
    for (int i = 0; i < 7; i++) begin
      if (e[i]) begin
        case (i)
          0: return 5'h00;
          1: return 5'h04;
          2: return 5'h05;
          3: return 5'h0C;
          4: return 5'h08;
          5: return 5'h09;
          default: return 5'h0A;
        endcase
      end
    end
    return (e != '0) ? 5'h1F : 5'h00;
  endfunction

  task automatic drive(input logic v, input logic [DATA_W-1:0] d1, input logic [DATA_W-1:0] d2,
                       input logic m2r, input logic cp0, input logic we,
                       input logic [REG_AW-1:0] dest, input logic [EXC_W-1:0] exc,
                       input logic [DATA_W-1:0] pc);
    ms_valid = v; ms_d1 = d1; ms_d2 = d2; ms_mem_to_reg = m2r; ms_from_cp0 = cp0;
    ms_rf_we = we; ms_dest = dest; ms_except = exc; ms_pc = pc;
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
  endtask

  // Advance the model over one posedge using the inputs currently driven,
  // then clock the DUT and return at the following negedge.
  task automatic tick();
    logic commit, allow, accept;
    commit = m_valid && !m_wait;
    allow  = !m_valid || commit;
    accept = ms_valid && allow;
    if (!resetn) begin
      m_valid = 1'b0; m_wait = 1'b0; m_cnt = '0;
    end else begin
      if (commit && m_exc == '0) m_cnt = m_cnt + 1'b1;
      if (m_valid && m_wait) begin
        m_data = cp0_rdata; m_wait = 1'b0;
      end else if (accept) begin
        m_valid = 1'b1;
        m_wait  = ms_from_cp0 && (ms_except == '0);
        m_we = ms_rf_we; m_dest = ms_dest; m_exc = ms_except; m_pc = ms_pc;
        m_data = ms_mem_to_reg ? ms_d1 : ms_d2;
      end else if (commit) begin
        m_valid = 1'b0;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    resetn = 1'b0; idle(); cp0_rdata = '0;
    tick(); tick();
    resetn = 1'b1;
    tests_run++;
    if (ws_allowin !== 1'b1) begin failures++; $display("FAIL reset_allowin got %b want 1", ws_allowin); end
    tests_run++;
    if ({rf_we, wb_except, cp0_rd_req, fwd_valid, fwd_data_ok} !== 5'b0) begin
      failures++; $display("FAIL reset_flags got %b want 00000", {rf_we, wb_except, cp0_rd_req, fwd_valid, fwd_data_ok});
    end
    tests_run++;
    if ({rf_waddr, rf_wdata, wb_excode, wb_epc, fwd_dest, fwd_data} !== '0) begin
      failures++; $display("FAIL reset_buses got nonzero rf_wdata=%h wb_epc=%h fwd_data=%h", rf_wdata, wb_epc, fwd_data);
    end
    tests_run++;
    if (retire_cnt !== '0) begin failures++; $display("FAIL reset_cnt got %0d want 0", retire_cnt); end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 32'h0, 32'h1234_5678, 1'b0, 1'b0, 1'b1, 5'd5, '0, 32'h100);
    tick();
    drive(1'b1, 32'hDEAD_BEEF, 32'h0, 1'b1, 1'b0, 1'b1, 5'd8, '0, 32'h104);
    tests_run++;
    if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd5, 32'h1234_5678}) begin
      failures++; $display("FAIL alu_commit got we=%b addr=%0d data=%h want 1/5/12345678", rf_we, rf_waddr, rf_wdata);
    end
    tests_run++;
    if (ws_allowin !== 1'b1) begin failures++; $display("FAIL alu_allowin got %b want 1", ws_allowin); end
    tick();
    idle();
    tests_run++;
    if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd8, 32'hDEAD_BEEF}) begin
      failures++; $display("FAIL load_commit got we=%b addr=%0d data=%h want 1/8/deadbeef", rf_we, rf_waddr, rf_wdata);
    end
    tests_run++;
    if (retire_cnt !== 8'd1) begin failures++; $display("FAIL cnt_after_alu got %0d want 1", retire_cnt); end
    tick();
    tests_run++;
    if (retire_cnt !== 8'd2 || rf_we !== 1'b0) begin
      failures++; $display("FAIL cnt_after_load got cnt=%0d we=%b want 2/0", retire_cnt, rf_we);
    end
  endtask

  task automatic test_mfc0();
    logic [CNT_W-1:0] c0;
    c0 = retire_cnt;
    drive(1'b1, 32'h0, 32'h5555_AAAA, 1'b0, 1'b1, 1'b1, 5'd9, '0, 32'h108);
    tick();
    idle();
    cp0_rdata = 32'h0000_0400;
    tests_run++;
    if ({cp0_rd_req, ws_allowin, fwd_data_ok, rf_we} !== 4'b1000) begin
      failures++; $display("FAIL mfc0_wait got req/allow/ok/we=%b want 1000", {cp0_rd_req, ws_allowin, fwd_data_ok, rf_we});
    end
    tests_run++;
    if (fwd_valid !== 1'b1 || fwd_dest !== 5'd9) begin
      failures++; $display("FAIL mfc0_fwd got valid=%b dest=%0d want 1/9", fwd_valid, fwd_dest);
    end
    tick();
    cp0_rdata = '0;
    tests_run++;
    if ({rf_we, rf_waddr, rf_wdata, cp0_rd_req} !== {1'b1, 5'd9, 32'h400, 1'b0}) begin
      failures++; $display("FAIL mfc0_commit got we=%b addr=%0d data=%h req=%b want 1/9/400/0", rf_we, rf_waddr, rf_wdata, cp0_rd_req);
    end
    tick();
    tests_run++;
    if (retire_cnt !== c0 + 8'd1) begin failures++; $display("FAIL mfc0_cnt got %0d want %0d", retire_cnt, c0 + 8'd1); end
  endtask

  task automatic test_exception();
    logic [CNT_W-1:0] c0;
    c0 = retire_cnt;
    drive(1'b1, 32'h0, 32'h77, 1'b0, 1'b1, 1'b1, 5'd3, 9'b0_0000_1010, 32'hBFC0_0100);
    tick();
    drive(1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 5'd4, 9'b1_0000_0000, 32'hBFC0_0200);
    tests_run++;
    if ({wb_except, wb_excode, wb_epc} !== {1'b1, 5'h04, 32'hBFC0_0100}) begin
      failures++; $display("FAIL exc_adel got exc=%b code=%h epc=%h want 1/04/bfc00100", wb_except, wb_excode, wb_epc);
    end
    tests_run++;
    if ({rf_we, fwd_valid, cp0_rd_req} !== 3'b000) begin
      failures++; $display("FAIL exc_suppress got we/fwd/req=%b want 000", {rf_we, fwd_valid, cp0_rd_req});
    end
    tick();
    idle();
    tests_run++;
    if ({wb_except, wb_excode, wb_epc} !== {1'b1, 5'h1F, 32'hBFC0_0200}) begin
      failures++; $display("FAIL exc_high got exc=%b code=%h epc=%h want 1/1f/bfc00200", wb_except, wb_excode, wb_epc);
    end
    tick();
    tests_run++;
    if ({wb_except, wb_excode, wb_epc} !== '0 || retire_cnt !== c0) begin
      failures++; $display("FAIL exc_after got exc=%b code=%h cnt=%0d want 0/00/%0d", wb_except, wb_excode, retire_cnt, c0);
    end
  endtask

  task automatic test_reset_in_wait();
    drive(1'b1, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 5'd10, '0, 32'h200);
    tick();
    idle();
    tests_run++;
    if (cp0_rd_req !== 1'b1) begin failures++; $display("FAIL rstwait_pre got req=%b want 1", cp0_rd_req); end
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    tests_run++;
    if ({ws_allowin, rf_we, wb_except, cp0_rd_req, fwd_valid} !== 5'b10000 || retire_cnt !== '0) begin
      failures++; $display("FAIL rstwait_post got allow/we/exc/req/fwd=%b cnt=%0d want 10000/0",
                           {ws_allowin, rf_we, wb_except, cp0_rd_req, fwd_valid}, retire_cnt);
    end
    tick();
    tests_run++;
    if (rf_we !== 1'b0 || retire_cnt !== '0) begin
      failures++; $display("FAIL rstwait_nocommit got we=%b cnt=%0d want 0/0", rf_we, retire_cnt);
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 256; i++) begin
      drive(1'b1, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0, 1'b1, 5'($urandom_range(0, 31)), '0, $urandom);
      tick();
    end
    idle();
    tests_run++;
    if (retire_cnt !== 8'd255) begin failures++; $display("FAIL wrap_pre got %0d want 255", retire_cnt); end
    tick();
    tests_run++;
    if (retire_cnt !== 8'd0) begin failures++; $display("FAIL wrap_post got %0d want 0", retire_cnt); end
  endtask

  task automatic test_random();
    logic commit, e_exc;
    int errs;
    errs = 0;
    for (int n = 0; n < 500; n++) begin
      commit = m_valid && !m_wait;
      e_exc  = commit && (m_exc != '0);
      tests_run++;
      if (ws_allowin !== (!m_valid || commit) || cp0_rd_req !== (m_valid && m_wait) ||
          fwd_data_ok !== commit || fwd_valid !== (m_valid && m_we && m_exc == '0) ||
          rf_we !== (commit && m_we && m_exc == '0) || wb_except !== e_exc ||
          wb_excode !== (e_exc ? ref_excode(m_exc) : 5'h00) ||
          wb_epc !== (e_exc ? m_pc : '0) || retire_cnt !== m_cnt ||
          (m_valid && (fwd_dest !== m_dest || fwd_data !== m_data)) ||
          (commit && (rf_waddr !== m_dest || rf_wdata !== m_data))) begin
        failures++;
        if (errs < 10)
          $display("FAIL random cyc=%0d got allow=%b req=%b we=%b exc=%b code=%h cnt=%0d data=%h want allow=%b req=%b cnt=%0d data=%h",
                   n, ws_allowin, cp0_rd_req, rf_we, wb_except, wb_excode, retire_cnt, rf_wdata,
                   !m_valid || commit, m_valid && m_wait, m_cnt, m_data);
        errs++;
      end
      resetn = ($urandom_range(0, 59) != 0);
      cp0_rdata = $urandom;
      drive(($urandom_range(0, 3) != 0), $urandom, $urandom, 1'($urandom_range(0, 1)),
            ($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
            ($urandom_range(0, 3) == 0) ? 9'($urandom_range(1, 511)) : 9'd0, $urandom);
      tick();
    end
    resetn = 1'b1;
    idle();
  endtask

  initial begin
    resetn = 1'b0;
    idle();
    cp0_rdata = '0;
    @(negedge clk);
    test_reset();
    test_back_to_back();
    test_mfc0();
    test_exception();
    test_reset_in_wait();
    test_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule

// File: doc/wb_stage_pipe.md
Name: wb_stage_pipe

Overview:
Parametrised registered writeback stage: last pipeline stage after MEM. Holds one instruction behind a valid/allowin handshake and selects the result from memory data, ALU data or a CP0 read. MFC0-class reads take one extra cycle. Priority-encodes the exception vector to a MIPS ExcCode and drives the regfile write port, the ID-stage forwarding bus and a retired-instruction counter.

Parameters:
DATA_W, 32, datapath / PC width
EXC_W, 7, exception vector width (must be >= 7)
REG_AW, 5, regfile address width
CNT_W, 32, retire counter width

Ports:
clk  in  1  clock
resetn  in  1  synchronous active-low reset
ms_valid  in  1  MEM stage presents an instruction
ws_allowin  out  1  stage accepts an instruction this cycle
ms_d1  in  DATA_W  memory load data
ms_d2  in  DATA_W  ALU result
ms_mem_to_reg  in  1  1 = select ms_d1, 0 = select ms_d2
ms_from_cp0  in  1  result comes from a CP0 read
ms_rf_we  in  1  instruction writes the regfile
ms_dest  in  REG_AW  destination register
ms_except  in  EXC_W  exception vector, bit i = cause i
ms_pc  in  DATA_W  instruction PC
cp0_rd_req  out  1  CP0 read strobe
cp0_rdata  in  DATA_W  CP0 read data, combinational, valid while cp0_rd_req = 1
rf_we  out  1  regfile write enable
rf_waddr  out  REG_AW  regfile write address
rf_wdata  out  DATA_W  regfile write data
wb_except  out  1  exception commit pulse
wb_excode  out  5  ExcCode of the committing exception
wb_epc  out  DATA_W  PC of the excepting instruction
fwd_valid  out  1  stage holds a regfile-writing, non-excepting instruction
fwd_dest  out  REG_AW  forwarding destination
fwd_data_ok  out  1  fwd_data is final (0 while a CP0 read is pending)
fwd_data  out  DATA_W  forwarding data
retire_cnt  out  CNT_W  count of committed non-excepting instructions

Behaviour:
- Clock and reset: single clock; reset is synchronous, active-low.
- Reset values: state EMPTY, stage registers 0. All outputs 0 except ws_allowin = 1. retire_cnt = 0.
- FSM states:
  - EMPTY: no instruction held.
  - VALID: result final.
  - CP0_WAIT: CP0 read outstanding.
- Handshake:
  - ws_allowin = (state == EMPTY) || ready_go, where ready_go = (state == VALID).
  - Accept occurs at the posedge where ms_valid && ws_allowin.
  - On accept, latch all ms_* inputs. Latched data = ms_mem_to_reg ? ms_d1 : ms_d2.
- Transitions:
  - On accept: next state = CP0_WAIT if ms_from_cp0 && ms_except == 0, otherwise VALID.
  - CP0_WAIT -> VALID after exactly 1 cycle. That cycle has cp0_rd_req = 1, and cp0_rdata is captured into the data register at the posedge.
  - VALID -> VALID on a back-to-back accept; VALID -> EMPTY when no accept.
  - CP0_WAIT never accepts (ws_allowin = 0).
- Commit: occurs in any cycle with state == VALID; it lasts exactly one cycle.
  - Normal instruction: latency is 1 cycle in stage.
  - CP0 read: latency is 2 cycles in stage.
- Commit outputs, no exception (latched except == 0):
  - rf_we = latched rf_we.
  - rf_waddr / rf_wdata = latched dest / data.
  - retire_cnt increments by 1 at that posedge and wraps modulo 2^CNT_W.
- Commit outputs, with exception:
  - rf_we = 0, retire_cnt unchanged.
  - wb_except = 1, wb_excode per the encoding below, wb_epc = latched PC.
  - A CP0 read is never issued for an excepting instruction.
- Outside commit cycles: rf_we = 0, wb_except = 0, wb_excode = 0, wb_epc = 0.
- Exception encoding:
  - Priority encoder; lowest set bit wins, and multiple bits are legal.
  - Bit mapping: bit0 -> 0x00 Int, bit1 -> 0x04 AdEL, bit2 -> 0x05 AdES, bit3 -> 0x0C Ov, bit4 -> 0x08 Sys, bit5 -> 0x09 Bp, bit6 -> 0x0A RI.
  - Any bit >= 7 alone -> 0x1F.
- Forwarding:
  - fwd_valid = (state != EMPTY) && latched rf_we && latched except == 0.
  - fwd_data_ok = (state == VALID).
  - fwd_dest / fwd_data = latched values.
  - fwd_valid = 1 with fwd_dest = 0 is legal; the consumer ignores r0.
- Reset mid-operation (including during CP0_WAIT): return to EMPTY. No commit pulse, no regfile write, counter cleared.
- Stage never flushes itself. Redirect and flush of younger instructions belong to CP0/upstream.

Test Plan:
- Reset held 2 cycles, then released: all outputs 0, ws_allowin = 1, retire_cnt = 0.
- ALU op: ms_d2 = 0x1234_5678, ms_mem_to_reg = 0, ms_dest = 5, ms_rf_we = 1 -> next cycle rf_we = 1, rf_waddr = 5, rf_wdata = 0x1234_5678, retire_cnt 0 -> 1.
- Load: ms_d1 = 0xDEAD_BEEF, ms_mem_to_reg = 1, dest 8, issued back-to-back with the ALU op -> two consecutive commit cycles, ws_allowin stays 1, retire_cnt = 2.
- MFC0: ms_from_cp0 = 1, dest 9, cp0_rdata = 0x0000_0400 during the wait cycle:
  - cycle 1: cp0_rd_req = 1, ws_allowin = 0, fwd_data_ok = 0.
  - cycle 2: rf_we = 1, rf_wdata = 0x400.
- Exception priority: ms_except = 7'b0001010, ms_pc = 0xBFC0_0100, ms_rf_we = 1 -> wb_except = 1 for one cycle, wb_excode = 0x04, wb_epc = 0xBFC0_0100, rf_we = 0, retire_cnt unchanged, fwd_valid = 0.
- Reset asserted during CP0_WAIT -> next cycle state EMPTY, rf_we = 0, wb_except = 0, retire_cnt = 0. Also: retire_cnt preset path at 2^CNT_W − 1 plus one commit -> wraps to 0.
